// File: rtl/instruction_execute.sv
// instruction_execute: single-issue execute stage with a one-cycle ALU and a 4-cycle multiplier.
// Define LIMB_MUL_LONG_EN to add UMULL/SMULL/UMLAL/SMLAL; otherwise long multiplies retire as no-ops.
module instruction_execute (
    input  logic        clk,
    input  logic        rst,
    input  logic        e_exec,
    input  logic        e_do_cycle,
    input  logic        e_m_ma_cycle,
    input  logic [3:0]  e_dest,
    input  logic [3:0]  e_dest_lo,
    input  logic        e_write_dest_do,
    input  logic        e_write_dest_m,
    input  logic        e_write_cpsr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [3:0]  opcode,
    input  logic [2:0]  mul_type,
    output logic [31:0] result_o,
    output logic [31:0] result_hi_o,
    output logic        wr_en_o,
    output logic        wr_hi_en_o,
    output logic [3:0]  wr_dest_o,
    output logic [3:0]  wr_dest_hi_o,
    output logic [31:0] cpsr_o,
    output logic        busy_o
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic        busy_q;
    logic [31:0] result_q, result_hi_q;
    logic        wr_en_q, wr_hi_en_q;
    logic [3:0]  wr_dest_q, wr_dest_hi_q;
    logic [3:0]  nzcv_q;
    logic [31:0] ma_q, mb_q, md_q;
    logic [3:0]  mdest_q;
    logic        macc_q, mwr_q;

    logic        accept_s, mul_go_s, dp_go_s;
    logic [31:0] alu_x_s, alu_y_s, dp_res_s;
    logic        alu_cin_s, arith_s, alu_v_s, no_write_s;
    logic [32:0] alu_sum_s;
    logic [3:0]  nzcv_d;

    assign accept_s   = e_exec & ~busy_q;
    assign dp_go_s    = accept_s & ~e_m_ma_cycle & e_do_cycle;
    assign no_write_s = (opcode[3:2] == 2'b10);

`ifdef LIMB_MUL_LONG_EN
    logic [31:0] mc_q;
    logic [3:0]  mdest_lo_q;
    logic        mlong_q, msigned_q;
    logic [63:0] mul_x_s, mul_y_s, mul_acc_s, mul_sum_s;

    assign mul_go_s  = accept_s & e_m_ma_cycle;
    // Low 64 bits of the product of the extended operands are exact for both signednesses.
    assign mul_x_s   = msigned_q ? {{32{ma_q[31]}}, ma_q} : {32'h0, ma_q};
    assign mul_y_s   = msigned_q ? {{32{mb_q[31]}}, mb_q} : {32'h0, mb_q};
    assign mul_acc_s = ~macc_q ? 64'h0 : (mlong_q ? {mc_q, md_q} : {32'h0, md_q});
    assign mul_sum_s = mul_x_s * mul_y_s + mul_acc_s;
`else
    logic [31:0] mul_sum_s;
    logic        unused_long_s;

    assign mul_go_s      = accept_s & e_m_ma_cycle & ~mul_type[2];
    assign mul_sum_s     = ma_q * mb_q + (macc_q ? md_q : 32'h0);
    assign unused_long_s = ^{c, e_dest_lo, mul_type[1]};
`endif

    // ALU: arithmetic ops share one adder with operand swap/invert and selectable carry-in.
    always_comb begin
        alu_x_s   = a;
        alu_y_s   = b;
        alu_cin_s = 1'b0;
        arith_s   = 1'b1;
        case (opcode)
            4'h2, 4'hA: begin alu_y_s = ~b; alu_cin_s = 1'b1; end
            4'h3:       begin alu_x_s = b; alu_y_s = ~a; alu_cin_s = 1'b1; end
            4'h4, 4'hB: begin alu_cin_s = 1'b0; end
            4'h5:       begin alu_cin_s = nzcv_q[1]; end
            4'h6:       begin alu_y_s = ~b; alu_cin_s = nzcv_q[1]; end
            4'h7:       begin alu_x_s = b; alu_y_s = ~a; alu_cin_s = nzcv_q[1]; end
            default:    begin arith_s = 1'b0; end
        endcase
        alu_sum_s = {1'b0, alu_x_s} + {1'b0, alu_y_s} + {32'h0, alu_cin_s};
        alu_v_s   = (alu_x_s[31] == alu_y_s[31]) & (alu_sum_s[31] != alu_x_s[31]);
        case (opcode)
            4'h0, 4'h8: dp_res_s = a & b;
            4'h1, 4'h9: dp_res_s = a ^ b;
            4'hC:       dp_res_s = a | b;
            4'hD:       dp_res_s = b;
            4'hE:       dp_res_s = a & ~b;
            4'hF:       dp_res_s = ~b;
            default:    dp_res_s = alu_sum_s[31:0];
        endcase
        if (e_write_cpsr) begin
            nzcv_d = {dp_res_s[31], (dp_res_s == 32'h0),
                      arith_s ? alu_sum_s[32] : nzcv_q[1],
                      arith_s ? alu_v_s : nzcv_q[0]};
        end else begin
            nzcv_d = nzcv_q;
        end
    end

    // Control FSM plus all architectural state; write enables default low so they pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            busy_q       <= 1'b0;
            result_q     <= 32'h0;
            result_hi_q  <= 32'h0;
            wr_en_q      <= 1'b0;
            wr_hi_en_q   <= 1'b0;
            wr_dest_q    <= 4'h0;
            wr_dest_hi_q <= 4'h0;
            nzcv_q       <= 4'h0;
            ma_q         <= 32'h0;
            mb_q         <= 32'h0;
            md_q         <= 32'h0;
            mdest_q      <= 4'h0;
            macc_q       <= 1'b0;
            mwr_q        <= 1'b0;
`ifdef LIMB_MUL_LONG_EN
            mc_q         <= 32'h0;
            mdest_lo_q   <= 4'h0;
            mlong_q      <= 1'b0;
            msigned_q    <= 1'b0;
`endif
        end else begin
            wr_en_q    <= 1'b0;
            wr_hi_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mul_go_s) begin
                        state_q <= S_MUL;
                        busy_q  <= 1'b1;
                        cnt_q   <= 2'd0;
                        ma_q    <= a;
                        mb_q    <= b;
                        md_q    <= d;
                        mdest_q <= e_dest;
                        macc_q  <= mul_type[0];
                        mwr_q   <= e_write_dest_m;
`ifdef LIMB_MUL_LONG_EN
                        mc_q       <= c;
                        mdest_lo_q <= e_dest_lo;
                        mlong_q    <= mul_type[2];
                        msigned_q  <= mul_type[1];
`endif
                    end else if (dp_go_s) begin
                        result_q  <= dp_res_s;
                        wr_dest_q <= e_dest;
                        wr_en_q   <= e_write_dest_do & ~no_write_s;
                        nzcv_q    <= nzcv_d;
                    end
                end
                S_MUL: begin
                    if (cnt_q == 2'd3) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        cnt_q    <= 2'd0;
                        result_q <= mul_sum_s[31:0];
                        wr_en_q  <= mwr_q;
`ifdef LIMB_MUL_LONG_EN
                        if (mlong_q) begin
                            result_hi_q  <= mul_sum_s[63:32];
                            wr_dest_hi_q <= mdest_q;
                            wr_dest_q    <= mdest_lo_q;
                            wr_hi_en_q   <= mwr_q;
                        end else begin
                            wr_dest_q <= mdest_q;
                        end
`else
                        wr_dest_q <= mdest_q;
`endif
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= 2'd0;
                end
            endcase
        end
    end

    assign result_o     = result_q;
    assign result_hi_o  = result_hi_q;
    assign wr_en_o      = wr_en_q;
    assign wr_hi_en_o   = wr_hi_en_q;
    assign wr_dest_o    = wr_dest_q;
    assign wr_dest_hi_o = wr_dest_hi_q;
    assign cpsr_o       = {nzcv_q, 28'h0};
    assign busy_o       = busy_q;
endmodule
